// File: rtl/sitcpxg_rx_buffer_reader.sv
// Owns the SiTCP XG receive RAM: captures the core's big-endian byte writes, streams
// received bytes to user logic as left-justified beats and runs the buffer-clear handshake.
module sitcpxg_rx_buffer_reader #(
  parameter int ADDR_W = 16
) (
  input  logic        XGMII_CLOCK,
  input  logic        RSTs,
  input  logic [15:0] USER_RX_WADR,
  input  logic [7:0]  USER_RX_WENB,
  input  logic [63:0] USER_RX_WDAT,
  input  logic        USER_RX_CLR_ENB,
  output logic        USER_RX_CLR_REQ,
  output logic [15:0] USER_RX_RADR,
  output logic [15:0] USER_RX_SIZE,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [63:0] OUT_D,
  output logic [3:0]  OUT_B
);
  localparam int          WORDS     = 1 << (ADDR_W - 3);
  localparam logic [16:0] BUF_BYTES = 17'(1) << ADDR_W;

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, CLEAR} state_t;

  state_t            r_state, w_stateNext;
  logic [63:0]       r_mem [WORDS];
  logic [ADDR_W-1:0] r_wp, r_rp;
  logic              r_valid;
  logic [63:0]       r_d;
  logic [3:0]        r_b;

  logic              w_wrEn, w_accept, w_load;
  logic [ADDR_W-4:0] w_wrWord, w_rdWord;
  logic [3:0]        w_wrCnt, w_ldRoom, w_ldB;
  logic [2:0]        w_ldOff;
  logic [ADDR_W-1:0] w_wpNext, w_rpNext, w_availNow, w_availNext;
  logic [63:0]       w_rdData, w_ldMask, w_ldD;

  assign w_wrEn   = |USER_RX_WENB;
  assign w_wrWord = USER_RX_WADR[ADDR_W-1:3];

  always_comb begin
    w_wrCnt = '0;
    for (int i = 0; i < 8; i++) w_wrCnt = w_wrCnt + 4'(USER_RX_WENB[i]);
  end

  // Next pointers already include this edge's write and accept, so a beat loaded
  // now sees exactly the bytes that will be counted after the edge.
  assign w_accept    = r_valid & OUT_READY;
  assign w_wpNext    = w_wrEn ? USER_RX_WADR[ADDR_W-1:0] + ADDR_W'(w_wrCnt) : r_wp;
  assign w_rpNext    = w_accept ? r_rp + ADDR_W'(r_b) : r_rp;
  assign w_availNow  = r_wp - r_rp;
  assign w_availNext = w_wpNext - w_rpNext;

  assign w_ldOff  = w_rpNext[2:0];
  assign w_ldRoom = 4'd8 - {1'b0, w_ldOff};
  assign w_ldB    = (w_availNext < ADDR_W'(w_ldRoom)) ? w_availNext[3:0] : w_ldRoom;
  assign w_rdWord = w_rpNext[ADDR_W-1:3];

  // Same-edge writes to the word being read are forwarded so the beat matches the byte count.
  always_comb begin
    w_rdData = r_mem[w_rdWord];
    for (int l = 0; l < 8; l++)
      if (w_wrEn && (w_wrWord == w_rdWord) && USER_RX_WENB[7-l])
        w_rdData[63-8*l -: 8] = USER_RX_WDAT[63-8*l -: 8];
    w_ldMask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {w_ldB, 3'b000});
    w_ldD    = (w_rdData << {w_ldOff, 3'b000}) & w_ldMask;
  end

  always_ff @(posedge XGMII_CLOCK) begin
    if (w_wrEn)
      for (int l = 0; l < 8; l++)
        if (USER_RX_WENB[7-l]) r_mem[w_wrWord][63-8*l -: 8] <= USER_RX_WDAT[63-8*l -: 8];
  end

  always_comb begin
    w_stateNext     = r_state;
    w_load          = 1'b0;
    USER_RX_CLR_REQ = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_availNow != '0)   w_stateNext = FETCH;
        else if (USER_RX_CLR_ENB) w_stateNext = CLEAR;
      end
      FETCH: begin
        w_load      = 1'b1;
        w_stateNext = PRESENT;
      end
      PRESENT: begin
        if (w_accept) begin
          if (w_availNext != '0) w_load = 1'b1;
          else                   w_stateNext = IDLE;
        end
      end
      CLEAR: begin
        USER_RX_CLR_REQ = 1'b1;
        w_stateNext     = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge XGMII_CLOCK) begin
    if (RSTs) begin
      r_state <= IDLE;
      r_wp    <= '0;
      r_rp    <= '0;
      r_valid <= 1'b0;
      r_d     <= '0;
      r_b     <= '0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == CLEAR) begin
        r_wp <= '0;
        r_rp <= '0;
      end else begin
        r_wp <= w_wpNext;
        r_rp <= w_rpNext;
      end
      if (w_load) begin
        r_valid <= 1'b1;
        r_d     <= w_ldD;
        r_b     <= w_ldB;
      end else if (w_accept) begin
        r_valid <= 1'b0;
        r_d     <= '0;
        r_b     <= '0;
      end
    end
  end

  assign OUT_VALID    = r_valid;
  assign OUT_D        = r_d;
  assign OUT_B        = r_b;
  assign USER_RX_RADR = 16'(r_rp);
  assign USER_RX_SIZE = 16'(BUF_BYTES - 17'd16);

endmodule

// File: tb/tb_sitcpxg_rx_buffer_reader.sv
// Bench for sitcpxg_rx_buffer_reader: byte-array model of the receive stream checked
// every cycle, plus directed scenarios with hand-computed beats.
`timescale 1ns/1ps
module tb_sitcpxg_rx_buffer_reader;
  logic        clock = 1'b0;
  logic        rsts;
  logic [15:0] wadr;
  logic [7:0]  wenb;
  logic [63:0] wdat;
  logic        clrEnb, ready;
  logic        clrReq, outValid;
  logic [15:0] radr, rxSize;
  logic [63:0] outD;
  logic [3:0]  outB;
  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  sitcpxg_rx_buffer_reader dut (
    .XGMII_CLOCK(clock), .RSTs(rsts),
    .USER_RX_WADR(wadr), .USER_RX_WENB(wenb), .USER_RX_WDAT(wdat),
    .USER_RX_CLR_ENB(clrEnb), .USER_RX_CLR_REQ(clrReq),
    .USER_RX_RADR(radr), .USER_RX_SIZE(rxSize),
    .OUT_VALID(outValid), .OUT_READY(ready), .OUT_D(outD), .OUT_B(outB)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] e, input logic [63:0] d);
    wadr = a;
    wenb = e;
    wdat = d;
    @(negedge clock);
    wenb = 8'h00;
  endtask

  function automatic logic [63:0] pat(input int w);
    logic [15:0] v;
    v = 16'(w);
    return {v, v ^ 16'hA5A5, ~v, v + 16'h1357};
  endfunction

  // Reference model: the stream is a byte array addressed by absolute position;
  // a beat is the bytes from the read pointer up to the word end or the write pointer.
  logic [7:0]  mMem [0:65535];
  logic [15:0] mWp = '0, mRp = '0;
  logic        mValid = 1'b0, mFetching = 1'b0, mClearing = 1'b0;
  logic [3:0]  mB = '0;
  logic [63:0] mD = '0;
  logic        sRst, sClrEnb, sReady;
  logic [15:0] sWadr;
  logic [7:0]  sWenb;
  logic [63:0] sWdat;

  always @(posedge clock) begin
    sRst    <= rsts;
    sWadr   <= wadr;
    sWenb   <= wenb;
    sWdat   <= wdat;
    sClrEnb <= clrEnb;
    sReady  <= ready;
  end

  task automatic loadBeat();
    int off, av;
    logic [15:0] a;
    off = int'(mRp[2:0]);
    av  = int'(16'(mWp - mRp));
    mB  = 4'((av < 8 - off) ? av : 8 - off);
    mD  = '0;
    for (int i = 0; i < int'(mB); i++) begin
      a = mRp + 16'(i);
      mD[63-8*i -: 8] = mMem[a];
    end
    mValid = 1'b1;
  endtask

  task automatic modelStep();
    int availPre, n;
    logic wasClearing;
    if (sRst) begin
      mWp = '0; mRp = '0; mValid = 1'b0; mFetching = 1'b0; mClearing = 1'b0;
      mB = '0; mD = '0;
      return;
    end
    availPre    = int'(16'(mWp - mRp));
    wasClearing = mClearing;
    mClearing   = 1'b0;
    n = 0;
    for (int l = 0; l < 8; l++)
      if (sWenb[7-l]) begin
        mMem[{sWadr[15:3], 3'(l)}] = sWdat[63-8*l -: 8];
        n++;
      end
    if (n != 0) mWp = sWadr + 16'(n);
    if (wasClearing) begin
      mWp = '0;
      mRp = '0;
    end else if (mValid) begin
      if (sReady) begin
        mRp = mRp + 16'(mB);
        mValid = 1'b0; mB = '0; mD = '0;
        if (mWp != mRp) loadBeat();
      end
    end else if (mFetching) begin
      mFetching = 1'b0;
      loadBeat();
    end else if (availPre != 0) begin
      mFetching = 1'b1;
    end else if (sClrEnb) begin
      mClearing = 1'b1;
    end
  endtask

  initial forever begin
    @(negedge clock);
    modelStep();
    checkOutput("valid", 64'(outValid), 64'(mValid));
    checkOutput("radr", 64'(radr), 64'(mRp));
    checkOutput("clrReq", 64'(clrReq), 64'(mClearing));
    if (mValid) begin
      checkOutput("beatBytes", 64'(outB), 64'(mB));
      checkOutput("beatData", outD, mD);
    end
  end

  initial begin
    #1000000;
    bad++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bit found;
    rsts = 1'b1; wadr = '0; wenb = '0; wdat = '0; clrEnb = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clock);
    checkOutput("rstValid", 64'(outValid), 64'd0);
    checkOutput("rstD", outD, 64'd0);
    checkOutput("rstB", 64'(outB), 64'd0);
    checkOutput("rstRadr", 64'(radr), 64'd0);
    checkOutput("rstClrReq", 64'(clrReq), 64'd0);
    checkOutput("rxSize", 64'(rxSize), 64'hFFF0);
    rsts = 1'b0;

    // Aligned full word: beat appears three cycles after the write
    ready = 1'b1;
    applyStimulus(16'd0, 8'hFF, 64'h0011223344556677);
    checkOutput("latT1", 64'(outValid), 64'd0);
    @(negedge clock);
    checkOutput("latT2", 64'(outValid), 64'd0);
    @(negedge clock);
    checkOutput("latT3", 64'(outValid), 64'd1);
    checkOutput("alignB", 64'(outB), 64'd8);
    checkOutput("alignD", outD, 64'h0011223344556677);
    @(negedge clock);
    checkOutput("alignRadr", 64'(radr), 64'd8);

    // Partial writes leaving the read pointer unaligned
    applyStimulus(16'd8, 8'hF8, 64'h0102030405000000);
    repeat (2) @(negedge clock);
    checkOutput("part5B", 64'(outB), 64'd5);
    checkOutput("part5D", outD, 64'h0102030405000000);
    @(negedge clock);
    checkOutput("part5Radr", 64'(radr), 64'd13);
    applyStimulus(16'd13, 8'h07, 64'h0000000000AABBCC);
    repeat (2) @(negedge clock);
    checkOutput("part3B", 64'(outB), 64'd3);
    checkOutput("part3D", outD, 64'hAABBCC0000000000);
    @(negedge clock);
    checkOutput("part3Radr", 64'(radr), 64'd16);

    // Backpressure: the presented 4-byte beat must not grow while more data arrives
    ready = 1'b0;
    applyStimulus(16'd16, 8'hF0, 64'h1112131400000000);
    repeat (2) @(negedge clock);
    checkOutput("bpValid", 64'(outValid), 64'd1);
    applyStimulus(16'd20, 8'h0F, 64'h0000000015161718);
    applyStimulus(16'd24, 8'hFF, 64'h2122232425262728);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput("holdB", 64'(outB), 64'd4);
      checkOutput("holdD", outD, 64'h1112131400000000);
    end
    ready = 1'b1;
    @(negedge clock);
    checkOutput("bp1Radr", 64'(radr), 64'd20);
    checkOutput("bp1B", 64'(outB), 64'd4);
    checkOutput("bp1D", outD, 64'h1516171800000000);
    @(negedge clock);
    checkOutput("bp2Radr", 64'(radr), 64'd24);
    checkOutput("bp2D", outD, 64'h2122232425262728);
    @(negedge clock);
    checkOutput("bp3Radr", 64'(radr), 64'd32);
    checkOutput("bp3Valid", 64'(outValid), 64'd0);

    // Clear requested with 12 bytes pending: the pulse waits for the drain
    ready = 1'b0;
    applyStimulus(16'd32, 8'hFF, 64'h3132333435363738);
    applyStimulus(16'd40, 8'hF0, 64'h4142434400000000);
    clrEnb = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("clrHeld", 64'(clrReq), 64'd0);
    end
    checkOutput("clrBeatB", 64'(outB), 64'd8);
    ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clock);
      if (clrReq) found = 1'b1;
    end
    checkOutput("clrSeen", 64'(found), 64'd1);
    checkOutput("clrRadrBefore", 64'(radr), 64'd44);
    clrEnb = 1'b0;
    @(negedge clock);
    checkOutput("clrPulseEnd", 64'(clrReq), 64'd0);
    checkOutput("clrRadr", 64'(radr), 64'd0);

    // Stream the whole buffer to bring both pointers to the last word, then wrap
    for (int w = 0; w < 8191; w++) applyStimulus(16'(w * 8), 8'hFF, pat(w));
    repeat (6) @(negedge clock);
    checkOutput("fillRadr", 64'(radr), 64'hFFF8);
    checkOutput("fillIdle", 64'(outValid), 64'd0);
    applyStimulus(16'hFFF8, 8'hFF, 64'hA1A2A3A4A5A6A7A8);
    applyStimulus(16'h0000, 8'hFF, 64'hB1B2B3B4B5B6B7B8);
    @(negedge clock);
    checkOutput("wrapTopD", outD, 64'hA1A2A3A4A5A6A7A8);
    checkOutput("wrapTopRadr", 64'(radr), 64'hFFF8);
    @(negedge clock);
    checkOutput("wrapZeroRadr", 64'(radr), 64'd0);
    checkOutput("wrapZeroD", outD, 64'hB1B2B3B4B5B6B7B8);
    @(negedge clock);
    checkOutput("wrapEndRadr", 64'(radr), 64'd8);

    // Reset while a beat is stalled drops it
    ready = 1'b0;
    applyStimulus(16'd8, 8'hFF, 64'h7172737475767778);
    repeat (2) @(negedge clock);
    checkOutput("midValid", 64'(outValid), 64'd1);
    rsts = 1'b1;
    @(negedge clock);
    checkOutput("midRstValid", 64'(outValid), 64'd0);
    checkOutput("midRstRadr", 64'(radr), 64'd0);
    checkOutput("midRstB", 64'(outB), 64'd0);
    checkOutput("midRstD", outD, 64'd0);
    rsts = 1'b0;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
